mac_array_ctrl: RTL and testbench

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

---
 rtl/mac_pkg.sv | 30 +++
 rtl/mac_ctrl_cnt.sv | 34 +++
 rtl/mac_array_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mac_array_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_pkg: shared state type, defaults and row-mask helper          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mac_pkg;

  localparam int DIM_DEF = 5;
  localparam int TW_DEF  = 8;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOAD_W = 5'b00010,
    STREAM = 5'b00100,
    DRAIN  = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  // Top n bits of a dim-wide vector set; rows are numbered MSB-first.
  function automatic logic [31:0] row_mask(input logic [2:0] n, input int dim);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if ((i < dim) && (i >= dim - int'(n))) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_ctrl_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_ctrl_cnt: loadable down-counter, saturates at 0, tc when 0    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mac_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign cnt_o = r_cnt;
  assign tc_o  = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mac_array_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_array_ctrl: weight-load / stream / drain sequencer for a      |
// | DIM x DIM MAC array. Optional MAC_CTRL_PERF_CNT_EN adds cyc_cnt_o.|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int TW  = TW_DEF
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           start_i,
  input  logic [2:0]     n_i,
  input  logic [TW-1:0]  t_i,
  input  logic           abort_i,
  output logic           enW_o,
  output logic           enI_o,
  output logic [DIM-1:0] vertical_en_o,
  output logic [2:0]     w_addr_o,
  output logic [TW-1:0]  in_addr_o,
  output logic           val_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
`ifdef MAC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]    cyc_cnt_o
`endif
);

  localparam int CW = $clog2((1 << TW) + 2 * DIM + 8);

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_n;
  logic [TW-1:0] r_t;
  logic          r_err;
  logic          w_legal;
  logic          w_start_ok;
  logic [2:0]    w_wcnt;
  logic          w_wtc;
  logic [TW-1:0] w_scnt;
  logic          w_stc;
  logic [CW-1:0] w_dcnt;
  logic          w_dtc;
  logic [CW-1:0] w_lat;

  assign w_legal    = (n_i != 3'd0) && (32'(n_i) <= 32'(DIM)) && (t_i != '0);
  assign w_start_ok = (r_state == IDLE) && start_i && !abort_i && w_legal;
  assign w_lat      = CW'(r_n) + CW'(DIM) - CW'(1);

  mac_ctrl_cnt #(.W(3)) u_wcnt (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .load_i     (w_start_ok),
    .load_val_i (n_i - 3'd1),
    .dec_i      (r_state == LOAD_W),
    .cnt_o      (w_wcnt),
    .tc_o       (w_wtc)
  );

  mac_ctrl_cnt #(.W(TW)) u_scnt (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .load_i     ((r_state == LOAD_W) && w_wtc),
    .load_val_i (r_t - TW'(1)),
    .dec_i      (r_state == STREAM),
    .cnt_o      (w_scnt),
    .tc_o       (w_stc)
  );

  mac_ctrl_cnt #(.W(CW)) u_dcnt (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .load_i     ((r_state == STREAM) && w_stc),
    .load_val_i (w_lat - CW'(1)),
    .dec_i      (r_state == DRAIN),
    .cnt_o      (w_dcnt),
    .tc_o       (w_dtc)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_t     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == IDLE) && start_i && !abort_i && !w_legal;
      if (w_start_ok) begin
        r_n <= n_i;
        r_t <= t_i;
      end
    end
  end

  // val_o is the stream window delayed by LAT, expressed through the
  // remaining counts so no separate elapsed-cycle counter is needed.
  always_comb begin
    w_next        = r_state;
    enW_o         = 1'b0;
    enI_o         = 1'b0;
    w_addr_o      = '0;
    in_addr_o     = '0;
    val_o         = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    vertical_en_o = DIM'(row_mask(r_n, DIM));
    case (r_state)
      IDLE: begin
        busy_o        = 1'b0;
        vertical_en_o = '0;
        if (w_start_ok) w_next = LOAD_W;
      end
      LOAD_W: begin
        enW_o    = 1'b1;
        w_addr_o = w_wcnt;
        if (w_wtc) w_next = STREAM;
      end
      STREAM: begin
        enI_o     = 1'b1;
        in_addr_o = r_t - TW'(1) - w_scnt;
        val_o     = (CW'(w_scnt) + w_lat) < CW'(r_t);
        if (w_stc) w_next = DRAIN;
      end
      DRAIN: begin
        val_o = w_dcnt < CW'(r_t);
        if (w_dtc) w_next = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy_o        = 1'b0;
        vertical_en_o = '0;
        w_next        = IDLE;
      end
    endcase
    if (abort_i && (r_state != IDLE)) w_next = IDLE;
  end

  assign err_o = r_err;

`ifdef MAC_CTRL_PERF_CNT_EN
  logic [31:0] r_job;
  logic [31:0] r_cyc;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_job <= '0;
      r_cyc <= '0;
    end else begin
      r_job <= (r_state == IDLE) ? 32'd0 : r_job + 32'd1;
      if (r_state == DONE) r_cyc <= r_job + 32'd1;
    end
  end

  assign cyc_cnt_o = r_cyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_array_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mac_array_ctrl: table-driven and randomized self-check         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_mac_array_ctrl;

  localparam int DIM = 5;
  localparam int TW  = 8;

  logic           CLK = 1'b0;
  logic           RSTN = 1'b0;
  logic           start_i = 1'b0;
  logic [2:0]     n_i = '0;
  logic [TW-1:0]  t_i = '0;
  logic           abort_i = 1'b0;
  logic           enW_o, enI_o, val_o, busy_o, done_o, err_o;
  logic [DIM-1:0] vertical_en_o;
  logic [2:0]     w_addr_o;
  logic [TW-1:0]  in_addr_o;
`ifdef MAC_CTRL_PERF_CNT_EN
  logic [31:0]    cyc_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    int             n;
    int             t;
    int             lat;
    logic [DIM-1:0] mask;
  } job_t;

  typedef struct {
    int n;
    int t;
  } bad_t;

  mac_array_ctrl #(.DIM(DIM), .TW(TW)) dut (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .start_i       (start_i),
    .n_i           (n_i),
    .t_i           (t_i),
    .abort_i       (abort_i),
    .enW_o         (enW_o),
    .enI_o         (enI_o),
    .vertical_en_o (vertical_en_o),
    .w_addr_o      (w_addr_o),
    .in_addr_o     (in_addr_o),
    .val_o         (val_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
`ifdef MAC_CTRL_PERF_CNT_EN
    ,
    .cyc_cnt_o     (cyc_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected trace from the job timeline: k=0 is the first cycle after the
  // accepting edge; weights, then inputs, then val_o LAT after first input.
  task automatic run_job(input int n, input int t, input int lat, input logic [DIM-1:0] mask);
    int last;
    n_i     = 3'(n);
    t_i     = TW'(t);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    last = n + t + lat + 1;
    for (int k = 0; k <= last; k++) begin
      bit ew, ei, ev, ed, eb;
      ew = (k < n);
      ei = (k >= n) && (k < n + t);
      ev = (k >= n + lat) && (k < n + lat + t);
      ed = (k == n + t + lat);
      eb = (k < last);
      check("enW", 32'(enW_o), 32'(ew));
      if (ew) check("w_addr", 32'(w_addr_o), 32'(n - 1 - k));
      check("enI", 32'(enI_o), 32'(ei));
      if (ei) check("in_addr", 32'(in_addr_o), 32'(k - n));
      check("val", 32'(val_o), 32'(ev));
      check("done", 32'(done_o), 32'(ed));
      check("busy", 32'(busy_o), 32'(eb));
      check("vertical_en", 32'(vertical_en_o), eb ? 32'(mask) : 32'd0);
      check("err_in_job", 32'(err_o), 32'd0);
      n_i     = 3'($urandom);
      t_i     = TW'($urandom);
      start_i = (k < last) ? 1'($urandom) : 1'b0;
      tick();
    end
    start_i = 1'b0;
`ifdef MAC_CTRL_PERF_CNT_EN
    check("cyc_cnt", cyc_cnt_o, 32'(n + t + lat + 1));
`endif
  endtask

  initial begin
    job_t jobs[6];
    bad_t bads[5];
    jobs[0] = '{5, 3,   9, 5'b11111};
    jobs[1] = '{1, 1,   5, 5'b10000};
    jobs[2] = '{3, 4,   7, 5'b11100};
    jobs[3] = '{2, 6,   6, 5'b11000};
    jobs[4] = '{4, 1,   8, 5'b11110};
    jobs[5] = '{1, 255, 5, 5'b10000};
    bads[0] = '{0, 3};
    bads[1] = '{6, 3};
    bads[2] = '{2, 0};
    bads[3] = '{7, 1};
    bads[4] = '{0, 0};

    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_enW", 32'(enW_o), 32'd0);
    check("rst_enI", 32'(enI_o), 32'd0);
    check("rst_val", 32'(val_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_vert", 32'(vertical_en_o), 32'd0);
    check("rst_waddr", 32'(w_addr_o), 32'd0);
    check("rst_inaddr", 32'(in_addr_o), 32'd0);
`ifdef MAC_CTRL_PERF_CNT_EN
    check("rst_cyc", cyc_cnt_o, 32'd0);
`endif
    @(negedge CLK);
    RSTN = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_job(jobs[i].n, jobs[i].t, jobs[i].lat, jobs[i].mask);
    end

    for (int i = 0; i < 5; i++) begin
      n_i     = 3'(bads[i].n);
      t_i     = TW'(bads[i].t);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("err_pulse", 32'(err_o), 32'd1);
      check("err_busy", 32'(busy_o), 32'd0);
      tick();
      check("err_clear", 32'(err_o), 32'd0);
      check("err_busy2", 32'(busy_o), 32'd0);
    end

    // start together with abort in IDLE: start dropped
    n_i     = 3'd2;
    t_i     = TW'(3);
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("abst_busy", 32'(busy_o), 32'd0);
    check("abst_enW", 32'(enW_o), 32'd0);
    check("abst_err", 32'(err_o), 32'd0);
    tick();
    check("abst_busy2", 32'(busy_o), 32'd0);

    // abort at the second input-shift cycle
    n_i     = 3'd2;
    t_i     = TW'(4);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    check("pre_abort_enI", 32'(enI_o), 32'd1);
    check("pre_abort_inaddr", 32'(in_addr_o), 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_enI", 32'(enI_o), 32'd0);
    check("abort_val", 32'(val_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_vert", 32'(vertical_en_o), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("post_abort_done", 32'(done_o), 32'd0);
      check("post_abort_busy", 32'(busy_o), 32'd0);
    end

    // asynchronous reset while draining
    n_i     = 3'd3;
    t_i     = TW'(2);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (6) tick();
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    check("pre_rst_enI", 32'(enI_o), 32'd0);
    #2;
    RSTN = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_val", 32'(val_o), 32'd0);
    check("arst_vert", 32'(vertical_en_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
    check("post_rst_done", 32'(done_o), 32'd0);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    run_job(3, 2, 7, 5'b11100);

    for (int j = 0; j < 25; j++) begin
      int n, t;
      logic [DIM-1:0] m;
      n = int'($urandom_range(1, DIM));
      t = int'($urandom_range(1, 30));
      m = DIM'(((1 << n) - 1) << (DIM - n));
      run_job(n, t, n + DIM - 1, m);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
